// File: rtl/snake_render_pkg.sv
// Shared constants, segment field helpers and FSM state encoding for the
// snake row renderer.
package snake_render_pkg;

  localparam int SEG_W = 12;
  localparam logic [SEG_W-1:0] EMPTY_SEG = 12'hFFF;

  localparam int NUM_SEGS_DEF = 30;
  localparam int CELL_PX_DEF  = 10;
  localparam int GRID_W_DEF   = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [5:0] seg_x(input logic [SEG_W-1:0] seg);
    return seg[11:6];
  endfunction

  function automatic logic [5:0] seg_y(input logic [SEG_W-1:0] seg);
    return seg[5:0];
  endfunction

endpackage

// File: rtl/snake_row_mask_builder.sv
// Scans one snapshot entry per cycle into a build mask for the current grid
// row, then commits it to the mask that the pixel side reads.
//   state     | meaning
//   ST_IDLE   | active mask stable, waiting for a scan trigger
//   ST_SCAN   | testing entry idx against the current row
//   ST_COMMIT | build masks copied into the active masks
module snake_row_mask_builder
  import snake_render_pkg::*;
#(
  parameter int NUM_SEGS = NUM_SEGS_DEF,
  parameter int GRID_W   = GRID_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [5:0]                row_i,
  input  logic [NUM_SEGS*SEG_W-1:0] snap_i,
  output logic                      busy_o,
  output logic                      commit_o,
  output logic [GRID_W-1:0]         mask_o,
  output logic [GRID_W-1:0]         head_o
);

  localparam int IDX_W = $clog2(NUM_SEGS);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GRID_W-1:0]    build_mask_q, build_mask_d;
  logic [GRID_W-1:0]    build_head_q, build_head_d;
  logic [GRID_W-1:0]    act_mask_q, act_mask_d;
  logic [GRID_W-1:0]    act_head_q, act_head_d;
  logic [SEG_W-1:0]     entry;
  logic                 hit;

  assign entry = snap_i[SEG_W*idx_q +: SEG_W];
  // The all-ones empty code is rejected even when the row itself is 63.
  assign hit   = (entry != EMPTY_SEG) && (seg_y(entry) == row_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      build_mask_q <= '0;
      build_head_q <= '0;
      act_mask_q   <= '0;
      act_head_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      build_mask_q <= build_mask_d;
      build_head_q <= build_head_d;
      act_mask_q   <= act_mask_d;
      act_head_q   <= act_head_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    build_mask_d = build_mask_q;
    build_head_d = build_head_q;
    act_mask_d   = act_mask_q;
    act_head_d   = act_head_q;
    commit_o     = 1'b0;
    if (start_i) begin
      state_d      = ST_SCAN;
      idx_d        = '0;
      build_mask_d = '0;
      build_head_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SCAN: begin
          if (hit) begin
            build_mask_d[seg_x(entry)] = 1'b1;
            if (idx_q == '0) build_head_d[seg_x(entry)] = 1'b1;
          end
          if (idx_q == IDX_W'(NUM_SEGS - 1)) state_d = ST_COMMIT;
          else                               idx_d   = idx_q + IDX_W'(1);
        end
        ST_COMMIT: begin
          act_mask_d = build_mask_q;
          act_head_d = build_head_q;
          commit_o   = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign mask_o = act_mask_q;
  assign head_o = act_head_q;

endmodule

// File: rtl/snake_row_renderer.sv
// Per-frame snake snapshot, row/sub-row tracking and per-pixel snake/head
// flag generation from the row occupancy mask.
module snake_row_renderer
  import snake_render_pkg::*;
#(
  parameter int NUM_SEGS = NUM_SEGS_DEF,
  parameter int CELL_PX  = CELL_PX_DEF,
  parameter int GRID_W   = GRID_W_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SEGS*SEG_W-1:0] snake_data,
  input  logic                      frame_start,
  input  logic                      line_start,
  input  logic                      line_first,
  input  logic                      pix_en,
  output logic                      snake_pix,
  output logic                      head_pix,
  output logic                      busy
);

  localparam int SUB_W = $clog2(CELL_PX);
  localparam int CI_W  = $clog2(GRID_W);
  localparam int COL_W = CI_W + 1;

  logic [NUM_SEGS*SEG_W-1:0] snap_q;
  logic                      pend_q;
  logic [5:0]                row_q, row_d;
  logic [SUB_W-1:0]          sub_q, sub_d;
  logic [SUB_W-1:0]          px_q;
  logic [COL_W-1:0]          col_q;
  logic                      snake_pix_q, head_pix_q;
  logic                      scan_start, commit, busy_w;
  logic [GRID_W-1:0]         mask, head_mask;
  logic                      col_in;

  always_comb begin
    row_d = row_q;
    sub_d = sub_q + SUB_W'(1);
    if (line_first) begin
      row_d = '0;
      sub_d = '0;
    end else if (sub_q == SUB_W'(CELL_PX - 1)) begin
      row_d = row_q + 6'd1;
      sub_d = '0;
    end
  end

  // A line_start during a scan always restarts it, whatever the new sub-row.
  assign scan_start = line_start && ((sub_d == '0) || busy_w);
  assign col_in     = (col_q < COL_W'(GRID_W));

  snake_row_mask_builder #(
    .NUM_SEGS (NUM_SEGS),
    .GRID_W   (GRID_W)
  ) u_builder (
    .clk_i    (clock),
    .rst_i    (reset),
    .start_i  (scan_start),
    .row_i    (row_q),
    .snap_i   (snap_q),
    .busy_o   (busy_w),
    .commit_o (commit),
    .mask_o   (mask),
    .head_o   (head_mask)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q      <= '1;
      pend_q      <= 1'b0;
      row_q       <= '0;
      sub_q       <= '0;
      px_q        <= '0;
      col_q       <= '0;
      snake_pix_q <= 1'b0;
      head_pix_q  <= 1'b0;
    end else begin
      if (line_start) begin
        row_q <= row_d;
        sub_q <= sub_d;
      end
      // Snapshot only moves while idle or at commit so a scan sees one frame.
      if (commit && (pend_q || frame_start)) begin
        snap_q <= snake_data;
        pend_q <= 1'b0;
      end else if (frame_start && !busy_w) begin
        snap_q <= snake_data;
      end else if (frame_start) begin
        pend_q <= 1'b1;
      end
      if (line_start) begin
        px_q  <= '0;
        col_q <= '0;
      end else if (pix_en) begin
        if (px_q == SUB_W'(CELL_PX - 1)) begin
          px_q <= '0;
          if (col_in) col_q <= col_q + COL_W'(1);
        end else begin
          px_q <= px_q + SUB_W'(1);
        end
      end
      snake_pix_q <= pix_en && col_in && mask[col_q[CI_W-1:0]];
      head_pix_q  <= pix_en && col_in && head_mask[col_q[CI_W-1:0]];
    end
  end

  assign snake_pix = snake_pix_q;
  assign head_pix  = head_pix_q;
  assign busy      = busy_w;

endmodule
